reg_file_mp: RTL and testbench
==============================

# reg_file_mp

Parametrised multi-port integer register file for the RV32 core, replacing the fixed 2-read/1-write register file. It provides NRD asynchronous read ports, one synchronous write port and an optional hardwired-zero entry 0. It adds a post-reset clear sequencer that zeroes every entry, a same-cycle write-to-read bypass, and a per-register busy scoreboard so decode can detect pending writes. It sits between decode (reads, reservations) and writeback (writes).

## Interface
- XLEN, 32, data width in bits
- NREG, 32, number of registers (power of two, ≥2)
- NRD, 2, number of read ports (1..4)
- AW, $clog2(NREG), register address width (derived, do not override)
- ZERO_REG, 1, 1 = entry 0 reads as zero, ignores writes and ignores reservations
- BYPASS, 1, 1 = a read of the register being written this cycle returns write_data

- clk  input  1  clock; all state updates on posedge
- rst  input  1  asynchronous, active-low reset
- Reg_write  input  1  write enable
- Rd  input  AW  write address
- write_data  input  XLEN  write data
- Rs  input  NRD*AW  read addresses; port k = Rs[k*AW +: AW]
- read_data  output  NRD*XLEN  read data; port k = read_data[k*XLEN +: XLEN]
- Rs_busy  output  NRD  port k's register has a pending reservation
- Rsv_valid  input  1  reserve Rsv_rd (mark busy) at this edge
- Rsv_rd  input  AW  register to reserve
- init_done  output  1  clear sequence complete; the file is usable

## Operation
- States: CLEAR, READY. The asynchronous assertion of rst (rst=0) forces CLEAR, clear counter = 0, all busy bits = 0, and init_done = 0. The assertion takes effect immediately, including in the middle of any operation.
- CLEAR: on each posedge with rst=1, write 0 to entry[counter] and increment counter. The posedge that clears entry NREG-1 moves the block to READY and sets init_done = 1.
- While in CLEAR:
  - Reg_write and Rsv_valid are ignored.
  - read_data is all zeros and Rs_busy is all zeros.
- READY write: if Reg_write=1 and not (ZERO_REG and Rd==0), entry[Rd] <= write_data. The same edge clears busy[Rd].
- READY reserve: if Rsv_valid=1 and not (ZERO_REG and Rsv_rd==0), busy[Rsv_rd] <= 1.
  - If a write and a reservation hit the same register on the same edge, the reservation wins and busy stays 1.
  - Reserving an already-busy register keeps it at 1. No counting; one pending write per register is supported.
- Read port k (combinational) uses the first rule that applies:
  1. If ZERO_REG and Rs_k==0, the result is 0.
  2. If BYPASS, Reg_write=1, Rd==Rs_k and (Rd!=0 or ZERO_REG=0), the result is write_data.
  3. Otherwise the result is entry[Rs_k].
- Rs_busy[k] = busy[Rs_k]. Bypass does not mask Rs_busy; busy clears at the write edge.
- There are no X-initialised entries after reset: every entry is 0 once init_done=1.

## Timing
- Reset values: init_done=0, Rs_busy=0, read_data=0 (forced by CLEAR), all busy bits 0. Entry contents are undefined until cleared.
- Clear latency: exactly NREG posedges after rst deasserts. With the defaults, init_done is 1 after the 32nd rising edge.
- Write latency: 1 edge. With BYPASS=0, new data is readable in the cycle after the write edge. With BYPASS=1, it is readable in the same cycle.
- Reads: purely combinational from Rs, Reg_write, Rd, write_data and the state. There is no read latency.
- Busy: set or cleared at the posedge and visible on Rs_busy in the following cycle.
- Boundary cases:
  - Rd/Rsv_rd = NREG-1 is a valid address. There are no out-of-range addresses because NREG is a power of two.
  - If two read ports address the same register, both receive identical data.
  - If rst asserts during CLEAR, the sequence restarts from entry 0.

## Test plan
- Reset and clear:
  - Stimulus: hold rst=0, release it, and count edges.
  - Required: init_done=0 through edge 31 and 1 after edge 32.
  - Required: all 32 registers read 0.
  - Required: Reg_write of 0xDEAD to x5 during CLEAR is lost, and x5 reads 0 afterwards.
- Write and read:
  - Stimulus in READY: write x7=0x12345678 and x31=0xFFFFFFFF.
  - Required: port 0 on x7 and port 1 on x31 return those values on the next cycle.
  - Required: both ports reading x7 both give 0x12345678.
- Zero register:
  - Stimulus: write x0=0xAAAA5555 and reserve x0.
  - Required: x0 reads 0 and Rs_busy stays 0.
  - Required: a same-cycle bypass to Rs=0 also returns 0.
- Bypass:
  - Stimulus: with x3=0x11, assert Reg_write with Rd=3 and write_data=0x22 while Rs0=3.
  - Required: read_data port 0 = 0x22 in the same cycle when BYPASS=1, and 0x11 in that cycle when BYPASS=0.
- Scoreboard:
  - Stimulus: reserve x9.
  - Required: Rs_busy=1 for Rs=9 from the next cycle.
  - Stimulus: write x9.
  - Required: busy is cleared after the write edge.
  - Stimulus: write x9 and reserve x9 on the same edge.
  - Required: busy remains 1.
- Mid-operation reset:
  - Stimulus: reserve x4, write x4=0x99, then assert rst asynchronously between edges.
  - Required: init_done falls and Rs_busy falls immediately.
  - Required: after release and 32 edges, x4 reads 0 and is not busy.

Source files
------------

// File: rtl/reg_file_mp.sv
// Multi-port integer register file with post-reset clear sequencer,
// same-cycle write-to-read bypass and per-register busy scoreboard.
module reg_file_mp #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NREG     = 32,
  parameter int unsigned NRD      = 2,
  parameter int unsigned AW       = $clog2(NREG),
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                Reg_write,
  input  logic [AW-1:0]       Rd,
  input  logic [XLEN-1:0]     write_data,
  input  logic [NRD*AW-1:0]   Rs,
  output logic [NRD*XLEN-1:0] read_data,
  output logic [NRD-1:0]      Rs_busy,
  input  logic                Rsv_valid,
  input  logic [AW-1:0]       Rsv_rd,
  output logic                init_done
);

  typedef enum logic {CLEAR, READY} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic              clr_en, wr_en, rsv_en;
  logic [XLEN-1:0]   entries [NREG];
  logic [NREG-1:0]   busy;

  // State, clear counter and init_done registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= CLEAR;
      cnt_q     <= '0;
      init_done <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      init_done <= (state_d == READY);
    end
  end

  // Next-state and per-edge update enables
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_en  = 1'b0;
    wr_en   = 1'b0;
    rsv_en  = 1'b0;
    case (state_q)
      CLEAR: begin
        clr_en = 1'b1;
        cnt_d  = cnt_q + AW'(1);
        if (cnt_q == AW'(NREG - 1)) state_d = READY;
      end
      READY: begin
        wr_en  = Reg_write && !((ZERO_REG != 0) && (Rd == '0));
        rsv_en = Rsv_valid && !((ZERO_REG != 0) && (Rsv_rd == '0));
      end
      default: state_d = CLEAR;
    endcase
  end

  // Storage array; contents only become defined through the clear sweep
  always_ff @(posedge clk) begin
    if (clr_en) begin
      entries[cnt_q] <= '0;
    end else if (wr_en) begin
      entries[Rd] <= write_data;
    end
  end

  // Busy scoreboard; a reservation on the same edge overrides the write clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= '0;
    end else begin
      if (wr_en)  busy[Rd]     <= 1'b0;
      if (rsv_en) busy[Rsv_rd] <= 1'b1;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   rs;
    logic [XLEN-1:0] val;
    logic            zero_hit, byp_hit;

    assign rs       = Rs[k*AW +: AW];
    assign zero_hit = (ZERO_REG != 0) && (rs == '0);
    assign byp_hit  = (BYPASS != 0) && Reg_write && (Rd == rs) &&
                      ((Rd != '0) || (ZERO_REG == 0));

    // Read priority: hardwired zero, then bypass, then stored entry
    always_comb begin
      val = entries[rs];
      if (state_q != READY) val = '0;
      else if (zero_hit)    val = '0;
      else if (byp_hit)     val = write_data;
    end

    assign read_data[k*XLEN +: XLEN] = val;
    assign Rs_busy[k] = (state_q == READY) && busy[rs];
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp: a driver pushes model-predicted outputs,
// a negedge monitor pops and compares them against two DUTs (bypass on/off).
module tb_reg_file_mp;
  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 32;
  localparam int unsigned NRD  = 2;
  localparam int unsigned AW   = 5;

  logic                clk = 1'b0;
  logic                rst;
  logic                reg_write;
  logic [AW-1:0]       rd;
  logic [XLEN-1:0]     write_data;
  logic [NRD*AW-1:0]   rs_bus;
  logic [NRD*XLEN-1:0] read_data, read_data_nb;
  logic [NRD-1:0]      rs_busy, rs_busy_nb;
  logic                rsv_valid;
  logic [AW-1:0]       rsv_rd;
  logic                init_done, init_done_nb;

  always #5 clk = ~clk;

  reg_file_mp u_dut (
    .clk(clk), .rst(rst), .Reg_write(reg_write), .Rd(rd),
    .write_data(write_data), .Rs(rs_bus), .read_data(read_data),
    .Rs_busy(rs_busy), .Rsv_valid(rsv_valid), .Rsv_rd(rsv_rd),
    .init_done(init_done)
  );

  reg_file_mp #(.BYPASS(0)) u_dut_nb (
    .clk(clk), .rst(rst), .Reg_write(reg_write), .Rd(rd),
    .write_data(write_data), .Rs(rs_bus), .read_data(read_data_nb),
    .Rs_busy(rs_busy_nb), .Rsv_valid(rsv_valid), .Rsv_rd(rsv_rd),
    .init_done(init_done_nb)
  );

  typedef struct {
    int          kind;
    int          port;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: architectural register contents, busy flags, clear progress
  logic [31:0] m_reg  [NREG];
  bit          m_busy [NREG];
  bit          m_ready;
  int          m_cnt;

  task automatic model_reset();
    m_ready = 1'b0;
    m_cnt   = 0;
    for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
  endtask

  task automatic model_edge();
    if (!rst) begin
      model_reset();
    end else if (!m_ready) begin
      m_reg[m_cnt] = 32'h0;
      m_cnt++;
      if (m_cnt == NREG) m_ready = 1'b1;
    end else begin
      if (reg_write && rd != 0) begin
        m_reg[rd]  = write_data;
        m_busy[rd] = 1'b0;
      end
      if (rsv_valid && rsv_rd != 0) m_busy[rsv_rd] = 1'b1;
    end
  endtask

  function automatic logic [31:0] exp_read(logic [AW-1:0] a, bit byp);
    if (!m_ready) return 32'h0;
    if (a == 0) return 32'h0;
    if (byp && reg_write && rd == a) return write_data;
    return m_reg[a];
  endfunction

  task automatic push_expect();
    logic [AW-1:0] a;
    exp_t e;
    for (int k = 0; k < NRD; k++) begin
      a = rs_bus[k*AW +: AW];
      e.kind = 0; e.port = k; e.exp = exp_read(a, 1'b1); sb.push_back(e);
      e.kind = 1; e.port = k; e.exp = {31'h0, m_ready && m_busy[a]}; sb.push_back(e);
    end
    e.kind = 2; e.port = 0; e.exp = {31'h0, m_ready}; sb.push_back(e);
    a = rs_bus[AW-1:0];
    e.kind = 3; e.port = 0; e.exp = exp_read(a, 1'b0); sb.push_back(e);
  endtask

  // One cycle: advance the model across the edge, then drive new inputs
  task automatic step(input bit r, input bit we, input logic [AW-1:0] a_rd,
                      input logic [31:0] wd, input logic [AW-1:0] a0,
                      input logic [AW-1:0] a1, input bit rv,
                      input logic [AW-1:0] a_rsv);
    @(posedge clk);
    model_edge();
    #1;
    rst        = r;
    reg_write  = we;
    rd         = a_rd;
    write_data = wd;
    rs_bus     = {a1, a0};
    rsv_valid  = rv;
    rsv_rd     = a_rsv;
    if (!r) model_reset();
    push_expect();
  endtask

  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    string       nm;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        0:       begin act = read_data[e.port*XLEN +: XLEN]; nm = "read_data"; end
        1:       begin act = {31'h0, rs_busy[e.port]};       nm = "rs_busy"; end
        2:       begin act = {31'h0, init_done};             nm = "init_done"; end
        default: begin act = read_data_nb[XLEN-1:0];         nm = "read_data_nobypass"; end
      endcase
      checks++;
      if (act !== e.exp) begin
        failures++;
        $display("FAIL %s port%0d actual=%h required=%h t=%0t", nm, e.port, act, e.exp, $time);
      end
    end
  end

  initial begin
    int waited;
    rst = 1'b0; reg_write = 1'b0; rd = '0; write_data = '0;
    rs_bus = '0; rsv_valid = 1'b0; rsv_rd = '0;
    model_reset();

    #1;
    checks++;
    if (init_done !== 1'b0 || init_done_nb !== 1'b0) begin
      failures++;
      $display("FAIL reset init_done actual=%b/%b required=0 t=%0t", init_done, init_done_nb, $time);
    end
    checks++;
    if (rs_busy !== '0 || rs_busy_nb !== '0) begin
      failures++;
      $display("FAIL reset rs_busy actual=%b/%b required=0 t=%0t", rs_busy, rs_busy_nb, $time);
    end
    checks++;
    if (read_data !== '0 || read_data_nb !== '0) begin
      failures++;
      $display("FAIL reset read_data actual=%h/%h required=0 t=%0t", read_data, read_data_nb, $time);
    end

    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0);
    // Release and sweep; write/reserve during clear must be ignored
    for (int i = 0; i < 34; i++)
      step(1, i == 10, 5, 32'hDEAD, AW'(i % 32), AW'((i + 7) % 32), i == 12, 9);
    for (int i = 0; i < 16; i++)
      step(1, 0, 0, 0, AW'(2 * i), AW'(2 * i + 1), 0, 0);

    step(1, 1, 7,  32'h12345678, 7, 31, 0, 0);
    step(1, 1, 31, 32'hFFFFFFFF, 7, 31, 0, 0);
    step(1, 0, 0,  0,            7, 31, 0, 0);
    step(1, 0, 0,  0,            7, 7,  0, 0);

    step(1, 1, 0, 32'hAAAA5555, 0, 0, 1, 0);
    step(1, 0, 0, 0,            0, 0, 0, 0);

    step(1, 1, 3, 32'h11, 0, 0, 0, 0);
    step(1, 1, 3, 32'h22, 3, 3, 0, 0);
    step(1, 0, 0, 0,      3, 3, 0, 0);

    step(1, 0, 0, 0,      9, 9, 1, 9);
    step(1, 0, 0, 0,      9, 9, 0, 0);
    step(1, 1, 9, 32'h55, 9, 9, 0, 0);
    step(1, 0, 0, 0,      9, 9, 0, 0);
    step(1, 1, 9, 32'h66, 9, 9, 1, 9);
    step(1, 0, 0, 0,      9, 9, 0, 0);

    repeat (300)
      step(1, $urandom_range(0, 1) == 1, AW'($urandom), $urandom,
           AW'($urandom), AW'($urandom), $urandom_range(0, 3) == 0, AW'($urandom));

    step(1, 1, 4, 32'h99, 4, 4, 0, 0);
    step(1, 0, 0, 0,      4, 4, 1, 4);
    step(1, 0, 0, 0,      4, 4, 0, 0);
    step(0, 0, 0, 0,      4, 4, 0, 0);
    step(0, 0, 0, 0,      4, 4, 0, 0);
    for (int i = 0; i < 33; i++) step(1, 0, 0, 0, 4, 4, 0, 0);
    step(1, 0, 0, 0, 4, 31, 0, 0);

    waited = 0;
    while (!(init_done && init_done_nb) && waited < 40) begin
      @(posedge clk);
      waited++;
    end
    checks++;
    if (!(init_done === 1'b1 && init_done_nb === 1'b1)) begin
      failures++;
      $display("FAIL timeout waiting for init_done after %0d edges t=%0t", waited, $time);
    end

    @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
